// File: rtl/seq_mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Holds the controller state encoding and the default operand width.
package seq_mul_pkg;

    localparam int unsigned DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/seq_multiplier_param_if.sv
// Request/result bundle of the sequential multiplier.
// The master issues operands with start_bit; the slave returns product/ready_bit/busy.
interface seq_multiplier_param_if
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                   start_bit;
    logic                   is_signed;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic [2*WIDTH-1:0]     product;
    logic                   ready_bit;
    logic                   busy;

    modport master (
        output start_bit,
        output is_signed,
        output multiplicand,
        output multiplier,
        input  product,
        input  ready_bit,
        input  busy
    );

    modport slave (
        input  start_bit,
        input  is_signed,
        input  multiplicand,
        input  multiplier,
        output product,
        output ready_bit,
        output busy
    );
endinterface

// File: rtl/seq_mul_ctrl.sv
// Control FSM and bit counter of the sequential multiplier.
// Emits load/step strobes, flags the MSB step and the final step.
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic skip_i,
    output logic load_o,
    output logic step_o,
    output logic last_o,
    output logic done_o,
    output logic busy_o,
    output logic ready_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (load_o) state_d = CALC;
            CALC:       if (done_o) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // start_bit only counts outside CALC; a running operation is never disturbed
    always_comb begin
        load_o  = start_i && (state_q != CALC);
        step_o  = (state_q == CALC);
        busy_o  = (state_q == CALC);
        ready_o = (state_q == DONE);
        last_o  = step_o && (cnt_q == LAST);
        done_o  = last_o || (step_o && skip_i && (cnt_q == '0));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_o) begin
            cnt_d = '0;
        end else if (step_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/seq_multiplier_param.sv
// Parametrised signed/unsigned shift-add multiplier, one multiplier bit per cycle.
// Optional SEQ_MUL_ZERO_SKIP_EN finishes zero-operand requests in one cycle.
module seq_multiplier_param
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_multiplier_param_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic load, step, last, done, skip;
    logic busy, ready;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH+1:0]   hi, addend, sum;
    logic [2*WIDTH:0]   acc_step;

    seq_mul_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .start_i (bus.start_bit),
        .skip_i  (skip),
        .load_o  (load),
        .step_o  (step),
        .last_o  (last),
        .done_o  (done),
        .busy_o  (busy),
        .ready_o (ready)
    );

`ifdef SEQ_MUL_ZERO_SKIP_EN
    assign skip = (a_q == '0) || (b_q == '0);
`else
    assign skip = 1'b0;
`endif

    // Upper half is widened by one bit so the add/sub never overflows
    always_comb begin
        hi     = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH]};
        addend = {{2{sgn_q & a_q[WIDTH-1]}}, a_q};
        sum    = hi;
        if (b_q[0]) begin
            sum = (sgn_q && last) ? hi - addend : hi + addend;
        end
        acc_step = {sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sgn_d  = sgn_q;
        acc_d  = acc_q;
        prod_d = prod_q;
        if (load) begin
            a_d   = bus.multiplicand;
            b_d   = bus.multiplier;
            sgn_d = bus.is_signed;
            acc_d = '0;
        end else if (step) begin
            acc_d = acc_step;
            b_d   = b_q >> 1;
            if (done) begin
                prod_d = acc_step[2*WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            acc_q  <= '0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sgn_q  <= sgn_d;
            acc_q  <= acc_d;
            prod_q <= prod_d;
        end
    end

    assign bus.product   = prod_q;
    assign bus.ready_bit = ready;
    assign bus.busy      = busy;
endmodule

// File: doc/seq_multiplier_param.md
# seq_multiplier_param

Parametrised sequential shift-add multiplier, the next generation of the fixed 16-bit sequential multiplier. It handles operands of configurable width in either signed or unsigned mode, chosen per operation. It uses a start/ready handshake with a held result and a busy indication, and offers an optional zero-operand fast path. It sits in the arithmetic datapath wherever area matters more than throughput.

## Interface
- WIDTH, 16, operand width in bits; valid for 2 or more.
- CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, not overridden.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_bit  input  1  request; sampled on the rising edge.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
- multiplicand  input  WIDTH  operand A; captured on accept.
- multiplier  input  WIDTH  operand B; captured on accept.
- product  output  2*WIDTH  result; held stable while ready_bit=1.
- ready_bit  output  1  result valid.
- busy  output  1  calculation in progress; start_bit is ignored.

## Operation
- FSM states: IDLE, CALC, DONE; the state type lives in the package.
- Accept rule:
  - start_bit=1 on an edge in IDLE or DONE is accepted.
  - Accept captures multiplicand, multiplier and is_signed, clears the accumulator and counter, and moves to CALC.
  - start_bit in CALC is ignored: no capture, no effect on the running operation.
- CALC processes one multiplier bit per cycle, LSB first, using a right-shifting 2*WIDTH+1 accumulator:
  - Bits 0..WIDTH-2 add A (sign-extended if is_signed, else zero-extended) when set.
  - Bit WIDTH-1, when set, subtracts A in signed mode and adds A in unsigned mode.
  - After WIDTH steps, go to DONE and load product.
- DONE:
  - ready_bit=1; product holds until the next accept.
  - The state persists indefinitely without start_bit.
- Accept from DONE in the same edge:
  - ready_bit drops next cycle.
  - product keeps its old value until the new result loads.
- Arithmetic: product is the exact 2*WIDTH-bit result for all operand pairs, including the most negative times the most negative in signed mode. No overflow is possible.
- Reset (async, any state, including mid-CALC): state IDLE, product=0, ready_bit=0, busy=0, internal registers zeroed. An in-flight operation is discarded.

## Timing
- Accept at edge E0.
  - busy=1 from after E0 until edge E0+WIDTH.
  - ready_bit=1 and product valid from after edge E0+WIDTH.
  - Latency is WIDTH cycles; WIDTH=16 gives 16.
- Back-to-back throughput: one result per WIDTH+1 cycles. start_bit may be held high through DONE; it is accepted on the first DONE edge.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset deassertion: the first accept is possible on the first rising edge after rst goes high.

## Configuration
- SEQ_MUL_ZERO_SKIP_EN
  - Defined: if the captured multiplicand or multiplier is 0, the FSM goes IDLE/DONE to CALC to DONE in one cycle. ready_bit rises after E0+1 with product=0, and busy is high for that one cycle.
  - Undefined: every operation takes WIDTH cycles, including zero operands; the result is still 0.

## Structure
- Package seq_mul_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - a localparam default width of 16.
- One sub-module, seq_mul_ctrl, holds the FSM and the CNT_W bit counter. It drives load, step, done and busy.
- The top level holds the operand registers, the accumulator and the product register.

## Test plan
All scenarios use WIDTH=16.
- Signed -3 × 5 -> product=32'hFFFF_FFF1 (-15); ready_bit rises exactly 16 cycles after accept.
- Unsigned 16'hFFFF × 16'hFFFF -> 32'hFFFE_0001. The same bits with is_signed=1 -> 32'h0000_0001.
- Signed -32768 × -32768 -> 32'h4000_0000. Signed -32768 × 32767 -> 32'hC000_8000.
- Signed 7 × 9 accepted; start_bit pulsed with 100 × 100 at cycle 5 of CALC -> ignored, product=63, and busy stays high for cycles 1..16.
- Accept 1234 × 5678, then assert rst at cycle 8 -> product=0, ready_bit=0 and busy=0 immediately. After release, 2 × 3 -> 6 in 16 cycles.
- 0 × 1234:
  - With SEQ_MUL_ZERO_SKIP_EN: ready_bit after 1 cycle, product=0.
  - Without it: 16 cycles, product=0.
- 10000 random signed/unsigned pairs checked against a reference model, with 0 failures required.
